// File: rtl/icache_pkg.sv
// Shared constants, state type and line helpers for the instruction cache.
package icache_pkg;

    localparam int unsigned DEF_LINES      = 128;
    localparam int unsigned DEF_LINE_BYTES = 16;
    localparam int unsigned DEF_ADDR_W     = 32;

    localparam int unsigned OFFSET_W = $clog2(DEF_LINE_BYTES);
    localparam int unsigned INDEX_W  = $clog2(DEF_LINES);
    localparam int unsigned TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WSEL_W   = OFFSET_W - 2;
    localparam int unsigned LINE_W   = DEF_LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_e;

    // Pick one 32-bit instruction word out of a cache line.
    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                             input logic [WSEL_W-1:0] sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM: port A writes with a byte mask, port B reads with
// one cycle of latency.
module bram #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk_i,
    input  logic                     ena_i,
    input  logic [WIDTH/8-1:0]       wea_i,
    input  logic [$clog2(DEPTH)-1:0] addra_i,
    input  logic [WIDTH-1:0]         dia_i,
    input  logic                     enb_i,
    input  logic [$clog2(DEPTH)-1:0] addrb_i,
    output logic [WIDTH-1:0]         dob_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Byte-masked write on port A.
    always_ff @(posedge clk_i) begin
        if (ena_i) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (wea_i[b]) begin
                    mem_q[addra_i][b*8 +: 8] <= dia_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read on port B.
    always_ff @(posedge clk_i) begin
        if (enb_i) begin
            dob_o <= mem_q[addrb_i];
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: tags/valids in flops, line data in
// a block RAM, whole-line refill over a valid/ready memory port.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = DEF_LINES,
    parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    output logic                    resp_valid_o,
    output logic [31:0]             resp_data_o,
    input  logic                    flush_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_W-1:0]       mem_req_addr_o,
    input  logic                    mem_resp_valid_i,
    input  logic [LINE_BYTES*8-1:0] mem_resp_data_i
);

    localparam int unsigned OffW  = $clog2(LINE_BYTES);
    localparam int unsigned IdxW  = $clog2(LINES);
    localparam int unsigned TagW  = ADDR_W - IdxW - OffW;
    localparam int unsigned LineW = LINE_BYTES * 8;
    localparam int unsigned MaskW = LineW / 8;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TagW-1:0]   rd_tag_q, rd_tag_d;
    logic              rd_valid_q, rd_valid_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [TagW-1:0]   tag_q [LINES];
    logic [LINES-1:0]  valid_q;

    logic [IdxW-1:0]   req_idx, cur_idx;
    logic [TagW-1:0]   cur_tag;
    logic [OffW-3:0]   cur_wsel;
    logic              hit, fill, install, accept;
    logic [LineW-1:0]  dob;
    logic              unused_addr;

    assign req_idx     = req_addr_i[OffW +: IdxW];
    assign cur_idx     = addr_q[OffW +: IdxW];
    assign cur_tag     = addr_q[ADDR_W-1 -: TagW];
    assign cur_wsel    = addr_q[OffW-1:2];
    assign unused_addr = ^{req_addr_i[1:0], addr_q[1:0]};

    // A flush in the lookup cycle forces a miss even if the line was valid.
    assign hit     = (state_q == LOOKUP) && rd_valid_q && (rd_tag_q == cur_tag) && !flush_i;
    // Fill data is ignored outside MISS_WAIT, e.g. a late beat after reset.
    assign fill    = (state_q == MISS_WAIT) && mem_resp_valid_i && !rst_i;
    assign install = fill && !drop_q && !flush_i;

    assign req_ready_o     = (state_q == IDLE) || hit;
    assign accept          = req_valid_i && req_ready_o;
    assign resp_valid_o    = hit || fill;
    // Critical word is bypassed straight from the fill beat.
    assign resp_data_o     = (state_q == MISS_WAIT) ? word_sel(mem_resp_data_i, cur_wsel)
                                                    : word_sel(dob, cur_wsel);
    assign mem_req_valid_o = (state_q == MISS_REQ);
    assign mem_req_addr_o  = mem_req_addr_q;

    // Next-state and request-capture logic.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rd_tag_d       = rd_tag_q;
        rd_valid_d     = rd_valid_q;
        drop_d         = drop_q;
        mem_req_addr_d = mem_req_addr_q;
        case (state_q)
            IDLE: ;
            LOOKUP: begin
                if (hit) begin
                    state_d = IDLE;
                end else begin
                    state_d        = MISS_REQ;
                    mem_req_addr_d = {cur_tag, cur_idx, {OffW{1'b0}}};
                end
            end
            MISS_REQ: begin
                if (mem_req_ready_i) state_d = MISS_WAIT;
                if (flush_i) drop_d = 1'b1;
            end
            MISS_WAIT: begin
                if (fill) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Accepting in the flush cycle must see the valids already cleared.
        if (accept) begin
            state_d    = LOOKUP;
            addr_d     = req_addr_i;
            rd_tag_d   = tag_q[req_idx];
            rd_valid_d = valid_q[req_idx] && !flush_i;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            rd_tag_q       <= '0;
            rd_valid_q     <= 1'b0;
            drop_q         <= 1'b0;
            mem_req_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rd_tag_q       <= rd_tag_d;
            rd_valid_q     <= rd_valid_d;
            drop_q         <= drop_d;
            mem_req_addr_q <= mem_req_addr_d;
        end
    end

    // Valid bits: flush clears everything and beats a same-cycle install.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[cur_idx] <= 1'b1;
        end
    end

    // Tag array, written only when a line is actually installed.
    always_ff @(posedge clk_i) begin
        if (install) begin
            tag_q[cur_idx] <= cur_tag;
        end
    end

    bram #(
        .WIDTH(LineW),
        .DEPTH(LINES)
    ) u_data (
        .clk_i  (clk_i),
        .ena_i  (fill),
        .wea_i  ({MaskW{1'b1}}),
        .addra_i(cur_idx),
        .dia_i  (mem_resp_data_i),
        .enb_i  (accept),
        .addrb_i(req_idx),
        .dob_o  (dob)
    );

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a transaction-level cache model checked
// every cycle, plus hand-computed literal expectations.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         flush = 1'b0;
    logic         mem_req_ready = 1'b0;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;
    logic         req_ready, resp_valid, mem_req_valid;
    logic [31:0]  resp_data, mem_req_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .resp_valid_o    (resp_valid),
        .resp_data_o     (resp_data),
        .flush_i         (flush),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i (mem_resp_data)
    );

    // Backing memory contents: line 0x100 is the fixed pattern, others encode address.
    function automatic logic [127:0] line_data(input logic [31:0] la);
        if (la == 32'h100) return {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        return {32'h1000_0003 | la, 32'h1000_0002 | la, 32'h1000_0001 | la, 32'h1000_0000 | la};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [127:0] l;
        l = line_data(a & ~32'hF);
        return l[a[3:2] * 32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache model: what is installed, which request is being looked up, which miss is open.
    bit          m_valid [128];
    logic [20:0] m_tag [128];
    bit          pend, miss, sent, drop;
    logic [31:0] pend_addr, miss_addr;

    always @(negedge clk) begin : model
        bit          e_ready, e_resp, e_mreq, m_hit;
        logic [31:0] e_data;
        if (rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            pend = 0; miss = 0; sent = 0; drop = 0;
        end else begin
            e_ready = 0; e_resp = 0; e_mreq = 0; m_hit = 0; e_data = '0;
            if (pend) begin
                m_hit = m_valid[pend_addr[10:4]] && (m_tag[pend_addr[10:4]] == pend_addr[31:11])
                        && !flush;
                if (m_hit) begin
                    e_ready = 1; e_resp = 1; e_data = mem_word(pend_addr);
                end
            end else if (miss) begin
                if (!sent) begin
                    e_mreq = 1;
                end else if (mem_resp_valid) begin
                    e_resp = 1; e_data = mem_word(miss_addr);
                end
            end else begin
                e_ready = 1;
            end
            chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_resp});
            chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e_mreq});
            if (e_resp) chk("resp_data", resp_data, e_data);
            if (e_mreq) chk("mem_req_addr", mem_req_addr, miss_addr & ~32'hF);
            // Advance to what the next cycle must look like.
            if (pend) begin
                if (!m_hit) begin
                    miss = 1; miss_addr = pend_addr; sent = 0; drop = 0;
                end
            end else if (miss) begin
                if (!sent) begin
                    if (flush) drop = 1;
                    if (mem_req_ready) sent = 1;
                end else if (mem_resp_valid) begin
                    if (!drop && !flush) begin
                        m_valid[miss_addr[10:4]] = 1'b1;
                        m_tag[miss_addr[10:4]]   = miss_addr[31:11];
                    end
                    miss = 0;
                end else if (flush) begin
                    drop = 1;
                end
            end
            if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
            pend = req_valid && e_ready;
            if (pend) pend_addr = req_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete miss from an idle controller, with literal checks along the way.
    task automatic do_miss(input logic [31:0] addr, input int rdy_dly, input int rsp_dly,
                           input bit flush_wait, input bit flush_acc, input logic [31:0] exp_word);
        logic [31:0] la;
        la = addr & ~32'hF;
        step(); req_valid = 1'b1; req_addr = addr; flush = flush_acc;
        step(); req_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            step(); mem_req_ready = (i == rdy_dly);
            @(negedge clk);
            chk("miss_req_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("miss_req_addr", mem_req_addr, la);
            chk("miss_req_ready_low", {31'b0, req_ready}, 32'd0);
            chk("miss_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        step(); mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            flush = flush_wait && (i == 0);
            @(negedge clk);
            chk("wait_no_resp", {31'b0, resp_valid}, 32'd0);
            step();
        end
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = line_data(la);
        @(negedge clk);
        chk("fill_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("fill_resp_data", resp_data, exp_word);
        step(); mem_resp_valid = 1'b0; mem_resp_data = '0;
    endtask

    // Four back-to-back requests to one line; each must hit one cycle later.
    task automatic stream4(input logic [31:0] base, input logic [127:0] exp);
        for (int i = 0; i <= 4; i++) begin
            step();
            if (i < 4) begin
                req_valid = 1'b1; req_addr = base + 32'(4 * i);
            end else begin
                req_valid = 1'b0;
            end
            if (i > 0) begin
                @(negedge clk);
                chk("hit_valid", {31'b0, resp_valid}, 32'd1);
                chk("hit_data", resp_data, exp[(i-1)*32 +: 32]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'h0);

        // Cold miss, then the installed line streams as hits.
        do_miss(32'h104, 0, 2, 1'b0, 1'b0, 32'hBBBB);
        stream4(32'h100, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA});

        // Conflict on index 16 evicts, then the original line misses again.
        do_miss(32'h900, 0, 1, 1'b0, 1'b0, 32'h1000_0900);
        do_miss(32'h100, 0, 0, 1'b0, 1'b0, 32'hAAAA);

        // Request accepted together with flush must miss; refill then hits again.
        do_miss(32'h10C, 0, 1, 1'b0, 1'b1, 32'hDDDD);
        stream4(32'h100, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA});

        // Memory backpressure on the fill request.
        do_miss(32'h208, 5, 1, 1'b0, 1'b0, 32'h1000_0202);

        // Flush while waiting: data returned but not installed.
        do_miss(32'h304, 0, 2, 1'b1, 1'b0, 32'h1000_0301);
        do_miss(32'h304, 0, 1, 1'b0, 1'b0, 32'h1000_0301);

        // Reset in MISS_WAIT followed by a stray fill beat.
        step(); req_valid = 1'b1; req_addr = 32'h404;
        step(); req_valid = 1'b0;
        step(); mem_req_ready = 1'b1;
        step(); mem_req_ready = 1'b0; rst = 1'b1;
        step(); rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = line_data(32'h400);
        @(negedge clk);
        chk("stray_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("stray_no_mem_req", {31'b0, mem_req_valid}, 32'd0);
        chk("stray_ready", {31'b0, req_ready}, 32'd1);
        step(); mem_resp_valid = 1'b0; mem_resp_data = '0;
        do_miss(32'h404, 0, 1, 1'b0, 1'b0, 32'h1000_0401);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
